// File: rtl/up_down_counter_pkg.sv
// Shared encodings for the up/down counter family.
package up_down_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : up_down_counter_pkg

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with programmable terminal value, clear, load,
// wrap/saturate mode and registered overflow/underflow event pulses.
module param_up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             En,
    input  logic             UpOrDown,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Saturate,
    output logic [WIDTH-1:0] Count,
    output logic             Ovf,
    output logic             Unf,
    output logic             AtMax,
    output logic             AtZero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    // Parameter sanity at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("param_up_down_counter: WIDTH must be at least 2");
    end
    if (MAX_COUNT < 1 || (64'(MAX_COUNT) >> WIDTH) != 64'd0) begin : g_bad_max
        $error("param_up_down_counter: MAX_COUNT must be in 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    // Next count and terminal-event detection, in priority order.
    always_comb begin
        count_nxt = Count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (Clear) begin
            count_nxt = '0;
        end else if (Load) begin
            count_nxt = (LoadValue > MAX_VAL) ? MAX_VAL : LoadValue;
        end else if (En) begin
            if (UpOrDown == DIR_UP) begin
                if (Count == MAX_VAL) begin
                    ovf_nxt   = 1'b1;
                    count_nxt = (Saturate == MODE_SAT) ? MAX_VAL : '0;
                end else begin
                    count_nxt = Count + WIDTH'(1);
                end
            end else begin
                if (Count == '0) begin
                    unf_nxt   = 1'b1;
                    count_nxt = (Saturate == MODE_WRAP) ? MAX_VAL : '0;
                end else begin
                    count_nxt = Count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            Count <= '0;
            Ovf   <= 1'b0;
            Unf   <= 1'b0;
        end else begin
            Count <= count_nxt;
            Ovf   <= ovf_nxt;
            Unf   <= unf_nxt;
        end
    end

    // Bound flags decode the registered count directly.
    assign AtMax  = (Count == MAX_VAL);
    assign AtZero = (Count == '0);

endmodule : param_up_down_counter

// File: tb/tb_param_up_down_counter.sv
// Directed-vector bench for param_up_down_counter at WIDTH=4, MAX_COUNT=9.
module tb_param_up_down_counter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned MAXC  = 9;

    logic             Clk = 1'b0;
    logic             reset;
    logic             En;
    logic             UpOrDown;
    logic             Clear;
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic             Saturate;
    logic [WIDTH-1:0] Count;
    logic             Ovf;
    logic             Unf;
    logic             AtMax;
    logic             AtZero;

    int n_vec = 0;
    int n_err = 0;

    param_up_down_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .En        (En),
        .UpOrDown  (UpOrDown),
        .Clear     (Clear),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Saturate  (Saturate),
        .Count     (Count),
        .Ovf       (Ovf),
        .Unf       (Unf),
        .AtMax     (AtMax),
        .AtZero    (AtZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    int unsigned up_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int unsigned dn_exp [3]  = '{9, 8, 7};
    int unsigned sat_exp[3]  = '{9, 9, 9};
    int unsigned sov_exp[3]  = '{0, 1, 1};
    int unsigned tog_exp[4]  = '{5, 4, 5, 4};

    initial begin
        reset = 1'b0; En = 1'b0; UpOrDown = 1'b1; Clear = 1'b0;
        Load = 1'b0; LoadValue = '0; Saturate = 1'b0;
        #3;
        chk("rst_count", Count, 0);
        chk("rst_ovf", Ovf, 0);
        chk("rst_unf", Unf, 0);
        chk("rst_atzero", AtZero, 1);
        chk("rst_atmax", AtMax, 0);
        #4 reset = 1'b1;

        // Up, wrap mode
        En = 1'b1; UpOrDown = 1'b1; Saturate = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("up_count[%0d]", i), Count, up_exp[i]);
            chk($sformatf("up_ovf[%0d]", i), Ovf, (i == 9) ? 1 : 0);
        end

        // Down, wrap mode from zero
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        chk("clr_count", Count, 0);
        chk("clr_ovf", Ovf, 0);
        chk("pre_dn_atzero", AtZero, 1);
        UpOrDown = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("dn_count[%0d]", i), Count, dn_exp[i]);
            chk($sformatf("dn_unf[%0d]", i), Unf, (i == 0) ? 1 : 0);
        end

        // Saturate mode at both bounds
        Saturate = 1'b1; Load = 1'b1; LoadValue = 4'd8;
        step();
        Load = 1'b0;
        chk("sat_load", Count, 8);
        UpOrDown = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sat_up_count[%0d]", i), Count, sat_exp[i]);
            chk($sformatf("sat_up_ovf[%0d]", i), Ovf, sov_exp[i]);
            chk($sformatf("sat_up_atmax[%0d]", i), AtMax, 1);
        end
        Load = 1'b1; LoadValue = 4'd1;
        step();
        Load = 1'b0;
        chk("sat_load1", Count, 1);
        UpOrDown = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("sat_dn_count[%0d]", i), Count, 0);
            chk($sformatf("sat_dn_unf[%0d]", i), Unf, (i == 1) ? 1 : 0);
        end

        // Priority: clear over load over count; load clamps
        Saturate = 1'b0; UpOrDown = 1'b1;
        Clear = 1'b1; Load = 1'b1; En = 1'b1; LoadValue = 4'd5;
        step();
        chk("prio_clear", Count, 0);
        chk("prio_clear_ovf", Ovf, 0);
        Clear = 1'b0; LoadValue = 4'd15;
        step();
        chk("prio_clamp", Count, 9);
        chk("prio_clamp_atmax", AtMax, 1);
        chk("prio_clamp_ovf", Ovf, 0);
        Load = 1'b0;
        step();
        chk("wrap_after_clamp", Count, 0);
        chk("wrap_after_clamp_ovf", Ovf, 1);

        // Asynchronous reset mid-cycle
        En = 1'b0; Load = 1'b1; LoadValue = 4'd6;
        step();
        Load = 1'b0;
        chk("ar_pre", Count, 6);
        reset = 1'b0;
        #1;
        chk("ar_count", Count, 0);
        chk("ar_ovf", Ovf, 0);
        chk("ar_unf", Unf, 0);
        chk("ar_atzero", AtZero, 1);
        #1 reset = 1'b1;
        En = 1'b1; UpOrDown = 1'b1;
        step();
        chk("ar_resume0", Count, 1);
        step();
        chk("ar_resume1", Count, 2);

        // Direction toggling, then enable off
        En = 1'b0; Load = 1'b1; LoadValue = 4'd4;
        step();
        Load = 1'b0; En = 1'b1;
        for (int i = 0; i < 4; i++) begin
            UpOrDown = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            chk($sformatf("tog_count[%0d]", i), Count, tog_exp[i]);
            chk($sformatf("tog_pulse[%0d]", i), {31'd0, Ovf | Unf}, 0);
        end
        En = 1'b0;
        for (int i = 0; i < 2; i++) begin
            UpOrDown = (i == 0) ? 1'b1 : 1'b0;
            step();
            chk($sformatf("hold_count[%0d]", i), Count, 4);
            chk($sformatf("hold_pulse[%0d]", i), {31'd0, Ovf | Unf}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_param_up_down_counter
